spike_buf: RTL and testbench

// - Dual-clock mixed-width FIFO at the neuron ingress. Accepts FLIT_SIZE-bit flits from the router clock domain.
// - Delivers complete PACKET_SIZE-bit packets in the neuron clock domain.
// - The neuron interface drains it continuously with rdreq = ~rdempty and decodes the axon id from q.

---
 rtl/spike_buf_pkg.sv | 17 +
 rtl/spike_buf_sync.sv | 27 ++
 rtl/spike_buf.sv | 89 ++++++++
 tb/tb_spike_buf.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spike_buf_pkg.sv
// spike_buf_pkg: shared defaults and Gray-code helpers for the spike ingress FIFO.
// The helpers work on 32-bit vectors; callers zero-extend narrower pointers
// and size-cast the result back to the pointer width.
package spike_buf_pkg;
  localparam int FLIT_SIZE_DEF   = 4;
  localparam int PACKET_SIZE_DEF = 32;
  localparam int WR_DEPTH_DEF    = 64;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/spike_buf_sync.sv
// spike_buf_sync: W-bit two-flop synchronizer with asynchronous active-low clear.
// Ports:
//   clk_i  - destination-domain clock
//   rst_ni - asynchronous active-low clear
//   d_i    - signal from the source domain
//   q_o    - synchronized copy, two clk_i edges later
// Used for Gray pointers and, with d_i tied high, as a reset synchronizer
// (asynchronous assertion, synchronous deassertion).
module spike_buf_sync #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  assign q_o = sync_q;
endmodule

// File: rtl/spike_buf.sv
// spike_buf: dual-clock mixed-width FIFO, FLIT_SIZE-bit flits in (router_clk),
// PACKET_SIZE-bit packets out (neuron_clk), non-show-ahead registered read.
// Ports:
//   neuron_clk - read clock
//   rst_n      - asynchronous active-low reset for both domains
//   router_clk - write clock
//   wrreq/data - write one flit per router_clk edge unless wrfull
//   wrfull     - no free flit slot (router_clk domain)
//   rdreq      - pop one packet per neuron_clk edge unless rdempty
//   q          - packet popped by the previous accepted rdreq
//   rdempty    - fewer than RATIO flits stored (neuron_clk domain)
//   rdusedw    - complete packets available (only with SPIKE_BUF_USEDW_EN)
// Optional feature macro: SPIKE_BUF_USEDW_EN.
module spike_buf
  import spike_buf_pkg::*;
#(
  parameter int FLIT_SIZE   = FLIT_SIZE_DEF,
  parameter int PACKET_SIZE = PACKET_SIZE_DEF,
  parameter int WR_DEPTH    = WR_DEPTH_DEF
) (
  input  logic                   neuron_clk,
  input  logic                   rst_n,
  input  logic                   router_clk,
  input  logic                   wrreq,
  input  logic [FLIT_SIZE-1:0]   data,
  output logic                   wrfull,
  input  logic                   rdreq,
  output logic [PACKET_SIZE-1:0] q,
  output logic                   rdempty
`ifdef SPIKE_BUF_USEDW_EN
  ,
  output logic [$clog2(WR_DEPTH*FLIT_SIZE/PACKET_SIZE):0] rdusedw
`endif
);
  localparam int RATIO    = PACKET_SIZE / FLIT_SIZE;
  localparam int RD_DEPTH = WR_DEPTH / RATIO;
  localparam int K        = $clog2(RATIO);
  localparam int AW       = $clog2(WR_DEPTH);
  localparam int RAW      = $clog2(RD_DEPTH);
  localparam int PW       = AW + 1;
  localparam int GW       = RAW + 1;
  logic wr_rst_n, rd_rst_n;
  logic [PACKET_SIZE-1:0] mem [RD_DEPTH];
  logic [PW-1:0] wr_q, wr_d, wr_gray_q, wr_gray_r, wr_bin_r, rd_flit_w, fill;
  logic [GW-1:0] rd_q, rd_d, rd_gray_q, rd_gray_w, rd_bin_w;
  logic [PACKET_SIZE-1:0] q_q;
  logic wr_en, rd_en;
  spike_buf_sync #(.W(1)) u_wr_rst (.clk_i(router_clk), .rst_ni(rst_n), .d_i(1'b1), .q_o(wr_rst_n));
  spike_buf_sync #(.W(1)) u_rd_rst (.clk_i(neuron_clk), .rst_ni(rst_n), .d_i(1'b1), .q_o(rd_rst_n));
  spike_buf_sync #(.W(PW)) u_wr_ptr (.clk_i(neuron_clk), .rst_ni(rd_rst_n), .d_i(wr_gray_q), .q_o(wr_gray_r));
  spike_buf_sync #(.W(GW)) u_rd_ptr (.clk_i(router_clk), .rst_ni(wr_rst_n), .d_i(rd_gray_q), .q_o(rd_gray_w));
  // The read pointer is kept in packet units: a flit-unit pointer stepping by
  // RATIO would flip two Gray bits per read and could not cross domains safely.
  assign rd_bin_w  = GW'(gray2bin(32'(rd_gray_w)));
  assign rd_flit_w = {rd_bin_w, {K{1'b0}}};
  assign wrfull    = (wr_q - rd_flit_w) == PW'(WR_DEPTH);
  assign wr_en     = wrreq & ~wrfull;
  assign wr_d      = wr_q + PW'(wr_en);
  always_ff @(posedge router_clk or negedge wr_rst_n)
    if (!wr_rst_n) begin
      wr_q      <= '0;
      wr_gray_q <= '0;
    end else begin
      wr_q      <= wr_d;
      wr_gray_q <= PW'(bin2gray(32'(wr_d)));
    end
  // Packet-wide RAM with flit-lane writes; flit k of a packet lands in lane k.
  always_ff @(posedge router_clk)
    if (wr_en) mem[wr_q[AW-1:K]][FLIT_SIZE*wr_q[K-1:0] +: FLIT_SIZE] <= data;
  assign wr_bin_r = PW'(gray2bin(32'(wr_gray_r)));
  assign fill     = wr_bin_r - {rd_q, {K{1'b0}}};
  assign rdempty  = fill < PW'(RATIO);
  assign rd_en    = rdreq & ~rdempty;
  assign rd_d     = rd_q + GW'(rd_en);
  always_ff @(posedge neuron_clk or negedge rd_rst_n)
    if (!rd_rst_n) begin
      rd_q      <= '0;
      rd_gray_q <= '0;
      q_q       <= '0;
    end else begin
      rd_q      <= rd_d;
      rd_gray_q <= GW'(bin2gray(32'(rd_d)));
      q_q       <= rd_en ? mem[rd_q[RAW-1:0]] : q_q;
    end
  assign q = q_q;
`ifdef SPIKE_BUF_USEDW_EN
  assign rdusedw = fill[PW-1:K];
`endif
endmodule

// File: tb/tb_spike_buf.sv
// tb_spike_buf: randomized self-checking bench for spike_buf against a flit-queue model.
module tb_spike_buf;
  logic neuron_clk = 1'b0;
  logic router_clk = 1'b0;
  logic rst_n = 1'b0;
  logic wrreq = 1'b0;
  logic rdreq = 1'b0;
  logic [3:0] data = '0;
  logic wrfull, rdempty;
  logic [31:0] q;
`ifdef SPIKE_BUF_USEDW_EN
  logic [3:0] rdusedw;
`endif
  int n_chk = 0;
  int n_pass = 0;
  logic [3:0] fq [$];
  always #5 router_clk = ~router_clk;
  always begin
    #6 neuron_clk = 1'b1;
    #7 neuron_clk = 1'b0;
  end
  spike_buf dut (
    .neuron_clk(neuron_clk),
    .rst_n(rst_n),
    .router_clk(router_clk),
    .wrreq(wrreq),
    .data(data),
    .wrfull(wrfull),
    .rdreq(rdreq),
    .q(q),
    .rdempty(rdempty)
`ifdef SPIKE_BUF_USEDW_EN
    ,
    .rdusedw(rdusedw)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] pack(input logic [3:0] a [64], input int base);
    logic [31:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) p[4*k +: 4] = a[base+k];
    return p;
  endfunction
  task automatic write_flit(input logic [3:0] d);
    int n;
    n = 0;
    @(negedge router_clk);
    while (wrfull && n < 200) begin
      wrreq = 1'b0;
      n++;
      @(negedge router_clk);
    end
    if (wrfull) chk("wr_full_timeout", wrfull, 0);
    wrreq = 1'b1;
    data = d;
    fq.push_back(d);
  endtask
  task automatic wr_idle();
    @(negedge router_clk);
    wrreq = 1'b0;
  endtask
  task automatic rd_pkt();
    @(negedge neuron_clk);
    rdreq = 1'b1;
    @(negedge neuron_clk);
    rdreq = 1'b0;
  endtask
  task automatic wait_nonempty(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge neuron_clk);
      if (!rdempty) break;
    end
    chk(tag, rdempty, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [3:0] arr [64];
    logic [31:0] exp;
    int n, n_rx, cyc;
    logic pend;
    #25;
    chk("rst_rdempty", rdempty, 1);
    chk("rst_wrfull", wrfull, 0);
    chk("rst_q", q, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge neuron_clk);
    rd_pkt();
    chk("empty_read_q", q, 0);
    chk("empty_read_rdempty", rdempty, 1);
    for (int i = 1; i <= 8; i++) write_flit(4'(i));
    wr_idle();
    wait_nonempty("assembly_rdempty");
    rd_pkt();
    chk("assembly_q", q, 32'h87654321);
    chk("assembly_drained", rdempty, 1);
    for (int i = 0; i < 8; i++) arr[i] = 4'($urandom);
    for (int i = 0; i < 7; i++) write_flit(arr[i]);
    wr_idle();
    n = 0;
    repeat (20) begin
      @(negedge neuron_clk);
      if (!rdempty) n++;
    end
    chk("partial_nonempty_cycles", n, 0);
    write_flit(arr[7]);
    wr_idle();
    wait_nonempty("partial_complete");
    rd_pkt();
    chk("partial_q", q, pack(arr, 0));
    for (int i = 0; i < 64; i++) arr[i] = 4'($urandom);
    arr[0] = 4'h3;
    for (int i = 0; i < 64; i++) write_flit(arr[i]);
    wr_idle();
    chk("full_wrfull", wrfull, 1);
`ifdef SPIKE_BUF_USEDW_EN
    repeat (4) @(negedge neuron_clk);
    chk("full_usedw", rdusedw, 8);
`endif
    @(negedge router_clk);
    wrreq = 1'b1;
    data = 4'hF;
    @(negedge router_clk);
    wrreq = 1'b0;
    rd_pkt();
    chk("full_q0", q, pack(arr, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge router_clk);
      if (!wrfull) break;
    end
    chk("full_wrfull_fall", wrfull, 0);
    for (int p = 1; p < 8; p++) begin
      rd_pkt();
      chk("full_q", q, pack(arr, 8 * p));
    end
    repeat (4) @(negedge neuron_clk);
    chk("full_drained", rdempty, 1);
    fq.delete();
    n_rx = 0;
    cyc = 0;
    pend = 1'b0;
    fork
      begin
        for (int i = 0; i < 1600; i++) begin
          if ($urandom_range(0, 3) == 0) wr_idle();
          write_flit(4'($urandom));
        end
        wr_idle();
      end
      begin
        while (n_rx < 200 && cyc < 20000) begin
          @(negedge neuron_clk);
          cyc++;
          if (pend) begin
            if (fq.size() < 8) chk("stream_underflow", fq.size(), 8);
            else begin
              exp = '0;
              for (int k = 0; k < 8; k++) exp[4*k +: 4] = fq.pop_front();
              chk("stream_q", q, exp);
            end
            n_rx++;
          end
          pend = (n_rx < 200) && !rdempty;
          rdreq = pend;
        end
        rdreq = 1'b0;
      end
    join
    chk("stream_count", n_rx, 200);
    chk("stream_leftover", fq.size(), 0);
    for (int i = 0; i < 24; i++) write_flit(4'($urandom));
    wr_idle();
    repeat (5) @(negedge neuron_clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_rdempty", rdempty, 1);
    chk("midrst_wrfull", wrfull, 0);
    chk("midrst_q", q, 0);
    #30;
    rst_n = 1'b1;
    repeat (5) @(negedge neuron_clk);
    for (int i = 0; i < 8; i++) arr[i] = 4'($urandom);
    for (int i = 0; i < 8; i++) write_flit(arr[i]);
    wr_idle();
    wait_nonempty("midrst_packet_ready");
    rd_pkt();
    chk("midrst_q_after", q, pack(arr, 0));
    repeat (5) @(negedge neuron_clk);
    chk("midrst_one_packet", rdempty, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
